rename_unit: RTL
================

# rename_unit

Register-rename stage directly upstream of the reorder buffer. Each decoded instruction gets its architectural sources mapped to physical registers and, if it writes a destination, a fresh physical register from a free list. Downstream it supplies the ROB's `decode`, `rdaddr` and `pr` inputs; ROB commits return here to free old mappings. On flush, recovery uses a committed map, so speculative state rolls back in one cycle.

## Interface
- `ARCH_REGS`, 32: architectural registers; index width 5.
- `PHYS_REGS`, 64: physical registers; tag width 6; free-list depth `PHYS_REGS-ARCH_REGS` = 32.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dec_valid` in 1: decode presents an instruction.
- `dec_ready` out 1: rename accepts the instruction this cycle.
- `dec_rs1`, `dec_rs2` in 5: architectural sources.
- `dec_rd` in 5; `dec_rd_v` in 1: destination and its write enable.
- `dec_pc` in 64: PC, passed through.
- `ren_valid` out 1; `ren_ready` in 1: output handshake to ROB/dispatch.
- `ren_ps1`, `ren_ps2` out 6: physical sources.
- `ren_rd` out 5; `ren_rd_v` out 1; `ren_pd` out 6: destination, write enable, and newly allocated physical register.
- `ren_old_pd` out 6: previous mapping of `ren_rd`, freed at commit.
- `ren_pc` out 64.
- `cmt_valid` in 1; `cmt_rd_v` in 1; `cmt_rd` in 5; `cmt_pd` in 6; `cmt_old_pd` in 6: in-order commit from ROB.
- `flush` in 1: discard all uncommitted renames.

## Operation
- Speculative RAT (SRAT) and committed RAT (CRAT) each hold 32×6. Reset value of both: entry i = i.
- Free list is a 32-entry circular FIFO of 6-bit tags. It has three 6-bit pointers: `alloc_ptr`, `cmt_ptr` and `free_ptr`; bit 5 is the wrap bit. Reset: entries hold 32..63, `alloc_ptr`=`cmt_ptr`=0, `free_ptr`=32.
- Free count = `free_ptr - alloc_ptr` (6-bit modular arithmetic; 32 means full). Empty when count = 0.
- `dec_ready` = !rst && !flush && (!ren_valid || ren_ready) && (!dec_rd_v || count≠0).
- Accept (`dec_valid && dec_ready`):
  - Sources read from the SRAT value before this cycle's update. `rs==rd` therefore returns the old mapping.
  - If `dec_rd_v`: `ren_pd` = FIFO[alloc_ptr], `ren_old_pd` = SRAT[rd], SRAT[rd] ← `ren_pd`, `alloc_ptr`++.
  - If not `dec_rd_v`: `ren_pd` = 0, `ren_old_pd` = 0, no pop.
- Commit (`cmt_valid && cmt_rd_v`): CRAT[cmt_rd] ← `cmt_pd`; FIFO[free_ptr] ← `cmt_old_pd`, `free_ptr`++; `cmt_ptr`++. Commit with `cmt_rd_v`=0 changes nothing.
- Flush: SRAT ← CRAT (post-commit value of the same cycle); `alloc_ptr` ← `cmt_ptr` (post-increment); `ren_valid` ← 0. A decode is never accepted in a flush cycle.
- A tag freed in cycle N is allocatable from cycle N+1. There is no same-cycle bypass from free to allocate.
- Commit and accept in the same cycle are independent, except that the commit write to CRAT does not affect the SRAT.

## Timing
- Latency is 1 cycle: an instruction accepted in cycle N appears on `ren_*` with `ren_valid`=1 in cycle N+1.
- Output register holds its value while `ren_valid && !ren_ready`. The stage gives full throughput: back-to-back accepts are allowed when `ren_ready`=1.
- Reset values: `ren_valid`=0; `ren_ps1`, `ren_ps2`, `ren_pd`, `ren_old_pd`, `ren_rd`, `ren_rd_v`, `ren_pc` all = 0; `dec_ready`=0 while `rst` is high.
- Reset mid-operation discards everything: maps and free list return to their reset values.
- Wrap-around: pointers wrap at 64. Full and empty are distinguished only by the wrap bit.

## Configuration
- `RENAME_X0_EN` defined: architectural x0 is never renamed.
  - A destination with `dec_rd`=0 allocates nothing and outputs `ren_rd_v`=0, `ren_pd`=0.
  - A source of 0 always maps to tag 0.
  - Commits with `cmt_rd`=0 are ignored.
- `RENAME_X0_EN` undefined: x0 is renamed like any other register.

## Test plan
- After reset, rename rd=5, rs1=5 → `ren_ps1`=5, `ren_pd`=32, `ren_old_pd`=5. A next instruction with rs2=5 gets `ren_ps2`=32.
- 32 back-to-back rd-writing renames with no commit → `ren_pd` = 32..63; the 33rd rd-writer sees `dec_ready`=0, while an instruction with `dec_rd_v`=0 is still accepted.
- Commit `cmt_old_pd`=5 while the free list is empty → `dec_ready` stays 0 that cycle; in the next cycle the stalled instruction gets `ren_pd`=5.
- Rename rd=3 three times (pd 32, 33, 34), commit the first, then flush → SRAT[3]=32, and the next rd-writer gets `ren_pd`=33.
- `ren_ready`=0 for 4 cycles with `ren_valid`=1 → outputs stable, `dec_ready`=0; release → the next instruction follows 1 cycle later.
- With `RENAME_X0_EN`: rd=0, rs1=0 → `ren_rd_v`=0, `ren_ps1`=0, free count unchanged. Without the macro → `ren_pd`=32.

Source files
------------

// File: rtl/rename_unit.sv
// Register-rename stage: SRAT/CRAT map tables plus a circular free list of physical tags.
// Define RENAME_X0_EN to pin architectural x0 to physical tag 0 (never renamed).
module rename_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [$clog2(ARCH_REGS)-1:0] dec_rs1,
    input  logic [$clog2(ARCH_REGS)-1:0] dec_rs2,
    input  logic [$clog2(ARCH_REGS)-1:0] dec_rd,
    input  logic        dec_rd_v,
    input  logic [63:0] dec_pc,
    output logic        ren_valid,
    input  logic        ren_ready,
    output logic [$clog2(PHYS_REGS)-1:0] ren_ps1,
    output logic [$clog2(PHYS_REGS)-1:0] ren_ps2,
    output logic [$clog2(ARCH_REGS)-1:0] ren_rd,
    output logic        ren_rd_v,
    output logic [$clog2(PHYS_REGS)-1:0] ren_pd,
    output logic [$clog2(PHYS_REGS)-1:0] ren_old_pd,
    output logic [63:0] ren_pc,
    input  logic        cmt_valid,
    input  logic        cmt_rd_v,
    input  logic [$clog2(ARCH_REGS)-1:0] cmt_rd,
    input  logic [$clog2(PHYS_REGS)-1:0] cmt_pd,
    input  logic [$clog2(PHYS_REGS)-1:0] cmt_old_pd,
    input  logic        flush
);

    localparam int AW       = $clog2(ARCH_REGS);
    localparam int PW       = $clog2(PHYS_REGS);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FW       = $clog2(FL_DEPTH);
    localparam int PTRW     = FW + 1;

    logic [PW-1:0]   srat [ARCH_REGS];
    logic [PW-1:0]   crat [ARCH_REGS];
    logic [PW-1:0]   fifo [FL_DEPTH];
    logic [PTRW-1:0] alloc_ptr;
    logic [PTRW-1:0] cmt_ptr;
    logic [PTRW-1:0] free_ptr;
    logic [PTRW-1:0] free_count;

    logic            rd_alloc;
    logic            cmt_fire;
    logic            accept;
    logic [PW-1:0]   src1_tag;
    logic [PW-1:0]   src2_tag;
    logic [PW-1:0]   new_tag;

`ifdef RENAME_X0_EN
    assign rd_alloc = dec_rd_v && (dec_rd != '0);
    assign cmt_fire = cmt_valid && cmt_rd_v && (cmt_rd != '0);
    assign src1_tag = (dec_rs1 == '0) ? '0 : srat[dec_rs1];
    assign src2_tag = (dec_rs2 == '0) ? '0 : srat[dec_rs2];
`else
    assign rd_alloc = dec_rd_v;
    assign cmt_fire = cmt_valid && cmt_rd_v;
    assign src1_tag = srat[dec_rs1];
    assign src2_tag = srat[dec_rs2];
`endif

    // Wrap bit separates full (count = depth) from empty (count = 0).
    assign free_count = free_ptr - alloc_ptr;
    assign new_tag    = fifo[alloc_ptr[FW-1:0]];
    assign dec_ready  = !rst && !flush && (!ren_valid || ren_ready)
                        && (!rd_alloc || (free_count != '0));
    assign accept     = dec_valid && dec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ren_valid  <= 1'b0;
            ren_ps1    <= '0;
            ren_ps2    <= '0;
            ren_rd     <= '0;
            ren_rd_v   <= 1'b0;
            ren_pd     <= '0;
            ren_old_pd <= '0;
            ren_pc     <= '0;
        end else if (flush) begin
            ren_valid <= 1'b0;
        end else if (accept) begin
            ren_valid  <= 1'b1;
            ren_ps1    <= src1_tag;
            ren_ps2    <= src2_tag;
            ren_rd     <= dec_rd;
            ren_rd_v   <= rd_alloc;
            ren_pd     <= rd_alloc ? new_tag : '0;
            ren_old_pd <= rd_alloc ? srat[dec_rd] : '0;
            ren_pc     <= dec_pc;
        end else if (ren_ready) begin
            ren_valid <= 1'b0;
        end
    end

    // Flush restores the SRAT from the CRAT including this cycle's commit write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                srat[i] <= PW'(i);
            end
        end else if (flush) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                srat[i] <= (cmt_fire && (cmt_rd == AW'(i))) ? cmt_pd : crat[i];
            end
        end else if (accept && rd_alloc) begin
            srat[dec_rd] <= new_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                crat[i] <= PW'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fifo[i] <= PW'(ARCH_REGS + i);
            end
            cmt_ptr  <= '0;
            free_ptr <= PTRW'(FL_DEPTH);
        end else if (cmt_fire) begin
            crat[cmt_rd]             <= cmt_pd;
            fifo[free_ptr[FW-1:0]]   <= cmt_old_pd;
            free_ptr                 <= free_ptr + PTRW'(1);
            cmt_ptr                  <= cmt_ptr + PTRW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr <= '0;
        end else if (flush) begin
            alloc_ptr <= cmt_ptr + PTRW'(cmt_fire);
        end else if (accept && rd_alloc) begin
            alloc_ptr <= alloc_ptr + PTRW'(1);
        end
    end

endmodule
